// File: rtl/frame_rx_14443a_pkg.sv
// frame_rx_14443a_pkg: shared FSM encoding and frame geometry constants
package frame_rx_14443a_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_DONE} state_t;
  localparam logic [3:0] DATA_BITS = 4'd8;
  localparam logic [3:0] SHORT_FRAME_BITS = 4'd7;
endpackage

// File: rtl/frame_rx_shift.sv
// frame_rx_shift: LSB-first byte assembly, bit counter and running odd parity (parity kept only with FRAME_RX_14443A_PARITY_CHECK_EN)
module frame_rx_shift (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_shift,
  input  logic       i_data,
  output logic [7:0] o_byte,
  output logic [7:0] o_byte_nxt,
  output logic [3:0] o_bitcnt_nxt,
  output logic       o_par_mis
);
  logic [7:0] r_byte;
  logic [3:0] r_bitcnt;
  assign o_byte       = r_byte;
  assign o_byte_nxt   = r_byte | ({7'b0, i_shift & i_data} << r_bitcnt[2:0]);
  assign o_bitcnt_nxt = r_bitcnt + {3'b0, i_shift};
  // each strobe drops the bit into position bitcnt; unwritten positions stay 0
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_byte   <= '0;
      r_bitcnt <= '0;
    end else if (i_clr) begin
      r_byte   <= '0;
      r_bitcnt <= '0;
    end else if (i_shift) begin
      r_byte   <= o_byte_nxt;
      r_bitcnt <= o_bitcnt_nxt;
    end
`ifdef FRAME_RX_14443A_PARITY_CHECK_EN
  logic r_xor;
  // running XOR of data bits; the expected odd-parity bit is its complement
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_xor <= 1'b0;
    else if (i_clr) r_xor <= 1'b0;
    else if (i_shift) r_xor <= r_xor ^ i_data;
  assign o_par_mis = i_data == r_xor;
`else
  assign o_par_mis = 1'b0;
`endif
endmodule

// File: rtl/frame_rx_14443a.sv
// frame_rx_14443a: ISO 14443-A PCD->PICC frame receiver; parity checking enabled by FRAME_RX_14443A_PARITY_CHECK_EN
module frame_rx_14443a
  import frame_rx_14443a_pkg::*;
#(
  parameter int MAX_BYTES = 64,
  parameter int CNT_W = 7
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_enable,
  input  logic             in_data,
  input  logic             in_bit_valid,
  input  logic             in_eof,
  output logic [7:0]       out_byte,
  output logic             out_byte_valid,
  output logic             out_par_err,
  output logic             out_short_frame,
  output logic             out_frame_done,
  output logic             out_frame_err,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_byte_cnt
);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);
  state_t r_state, w_state_nxt;
  logic [7:0] r_byte, w_byte, w_byte_nxt;
  logic [CNT_W-1:0] r_byte_cnt;
  logic [3:0] w_bitcnt_nxt, w_bitcnt_upd;
  logic r_byte_valid, r_par_err, r_short, r_done, r_frame_err, r_ovf;
  logic w_bv_in, w_sof, w_shift, w_par_stb, w_clr, w_full, w_deliver, w_drop;
  logic w_eof, w_short, w_err, w_par_mis, w_par_err;
  frame_rx_shift u_shift (
    .i_clk       (in_clk),
    .i_rst       (in_rst),
    .i_clr       (w_clr),
    .i_shift     (w_shift),
    .i_data      (in_data),
    .o_byte      (w_byte),
    .o_byte_nxt  (w_byte_nxt),
    .o_bitcnt_nxt(w_bitcnt_nxt),
    .o_par_mis   (w_par_mis)
  );
  // state register
  always_ff @(posedge in_clk or posedge in_rst)
    if (in_rst) r_state <= ST_IDLE;
    else r_state <= w_state_nxt;
  // next state: EOF wins over the bit it arrives with, DONE lasts one cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   w_state_nxt = w_sof ? ST_DATA : ST_IDLE;
      ST_DATA:   w_state_nxt = in_eof ? ST_DONE : (w_shift && w_bitcnt_nxt == DATA_BITS) ? ST_PARITY : ST_DATA;
      ST_PARITY: w_state_nxt = in_eof ? ST_DONE : w_par_stb ? ST_DATA : ST_PARITY;
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (!in_enable) w_state_nxt = ST_IDLE;
  end
  // output decode: next values of the registered strobes and flags
  always_comb begin
    w_bv_in      = in_enable & in_bit_valid;
    w_sof        = r_state == ST_IDLE && w_bv_in && in_data;
    w_shift      = r_state == ST_DATA && w_bv_in;
    w_par_stb    = r_state == ST_PARITY && w_bv_in;
    w_clr        = !in_enable || w_sof || w_par_stb;
    w_full       = r_byte_cnt == MAX_CNT;
    w_deliver    = w_par_stb && !w_full;
    w_drop       = w_par_stb && w_full;
    w_par_err    = w_deliver && w_par_mis;
    w_eof        = in_enable && in_eof && (r_state == ST_DATA || r_state == ST_PARITY);
    w_bitcnt_upd = w_par_stb ? 4'd0 : w_bitcnt_nxt;
    w_short      = w_eof && w_bitcnt_upd == SHORT_FRAME_BITS && r_byte_cnt == '0;
    w_err        = w_eof && w_bitcnt_upd != 4'd0 && !w_short;
  end
  // registered outputs; SOF clears the per-frame count and sticky flags
  always_ff @(posedge in_clk or posedge in_rst)
    if (in_rst) begin
      r_byte       <= '0;
      r_byte_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_short      <= 1'b0;
      r_done       <= 1'b0;
      r_byte_cnt   <= '0;
      r_frame_err  <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_byte_valid <= w_deliver;
      r_par_err    <= w_par_err;
      r_short      <= w_short;
      r_done       <= w_eof;
      if (w_deliver) r_byte <= w_byte;
      else if (w_short) r_byte <= {1'b0, w_byte_nxt[6:0]};
      r_byte_cnt   <= w_sof ? '0 : w_deliver ? r_byte_cnt + CNT_W'(1) : r_byte_cnt;
      r_frame_err  <= w_sof ? 1'b0 : r_frame_err | w_err;
      r_ovf        <= w_sof ? 1'b0 : r_ovf | w_drop;
    end
  assign out_byte        = r_byte;
  assign out_byte_valid  = r_byte_valid;
  assign out_par_err     = r_par_err;
  assign out_short_frame = r_short;
  assign out_frame_done  = r_done;
  assign out_frame_err   = r_frame_err;
  assign out_ovf         = r_ovf;
  assign out_byte_cnt    = r_byte_cnt;
endmodule

// File: doc/frame_rx_14443a.md
FRAME_RX_14443A -- requirements
Module: frame_rx_14443a

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 64, meaning maximum data bytes accepted per frame.
REQ-002 SHALL have parameter CNT_W, default 7, meaning width of out_byte_cnt (must satisfy 2^CNT_W > MAX_BYTES).
REQ-003 in_clk  input  1  system clock, fc/4 (3.39 MHz), all logic on rising edge.
REQ-004 in_rst  input  1  reset, asynchronous, active-high.
REQ-005 in_enable  input  1  block enable; low = synchronous clear to IDLE.
REQ-006 in_data  input  1  decoded NRZ-L bit from the Miller-modified decoder.
REQ-007 in_bit_valid  input  1  one-cycle strobe, in_data valid this cycle (one per ETU).
REQ-008 in_eof  input  1  one-cycle strobe, end of frame detected upstream (no pause for 2 ETU).
REQ-009 out_byte  output  8  assembled data byte, LSB received first.
REQ-010 out_byte_valid  output  1  one-cycle strobe, out_byte valid.
REQ-011 out_par_err  output  1  one-cycle strobe coincident with out_byte_valid, parity mismatch.
REQ-012 out_short_frame  output  1  one-cycle strobe, 7-bit short frame complete (out_byte[6:0] valid, bit 7 = 0).
REQ-013 out_frame_done  output  1  one-cycle strobe at end of every frame.
REQ-014 out_frame_err  output  1  sticky until next SOF, EOF at illegal bit position.
REQ-015 out_ovf  output  1  sticky until next SOF, byte count exceeded MAX_BYTES.
REQ-016 out_byte_cnt  output  CNT_W  bytes delivered in current/last frame.

Function
REQ-017 FSM states SHALL be IDLE, DATA, PARITY, with DONE held for exactly one cycle.
REQ-018 IDLE: a bit strobe with in_data=1 (SOF) SHALL move to DATA, clear bit counter, out_byte_cnt, out_frame_err and out_ovf; in_data=0 strobes SHALL be ignored.
REQ-019 DATA: each strobe SHALL shift in_data into bit position bitcnt (LSB first) and increment bitcnt; after the 8th bit the FSM SHALL move to PARITY.
REQ-020 PARITY: on the strobe, received bit SHALL be compared to odd parity (XNOR-reduce of the 8 data bits); the FSM SHALL return to DATA with bitcnt=0.
REQ-021 out_byte_valid SHALL assert exactly 1 cycle after the parity-bit strobe, out_byte stable until the next out_byte_valid.
REQ-022 out_byte_cnt SHALL increment with each out_byte_valid and saturate at MAX_BYTES.
REQ-023 The byte after MAX_BYTES bytes SHALL NOT raise out_byte_valid; it SHALL set out_ovf and be dropped.
REQ-024 in_eof in DATA with bitcnt=7 and out_byte_cnt=0 SHALL assert out_short_frame and out_frame_done 1 cycle later.
REQ-025 in_eof in DATA with bitcnt=0 SHALL assert out_frame_done only; any other bitcnt, or in_eof in PARITY, SHALL also set out_frame_err.
REQ-026 in_eof in IDLE SHALL be ignored.
REQ-027 Simultaneous in_bit_valid and in_eof SHALL process the bit first, then evaluate EOF on the updated bitcnt.
REQ-028 After DONE the FSM SHALL return to IDLE.
REQ-029 Strobe outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-030 in_rst high SHALL asynchronously force IDLE, bitcnt=0, out_byte=0x00, out_byte_cnt=0 and all strobes and flags 0.
REQ-031 Reset or in_enable low mid-frame SHALL discard the partial byte and emit no strobe.

Configuration
REQ-032 Macro FRAME_RX_14443A_PARITY_CHECK_EN defined: REQ-020 comparison active, out_par_err driven.
REQ-033 Macro undefined: the parity bit SHALL still be consumed for framing, and out_par_err SHALL be tied 0.

Structure
REQ-034 Package frame_rx_14443a_pkg SHALL hold the state enumeration, DATA_BITS=8 and SHORT_FRAME_BITS=7.
REQ-035 Sub-module frame_rx_shift SHALL contain the 8-bit shift register, bit counter and running parity.

Verification
REQ-036 SOF, bits of 0xA5 LSB-first, parity 1, EOF -> out_byte=0xA5 valid, out_par_err=0, out_byte_cnt=1, out_frame_done.
REQ-037 SOF, 0xA5, parity 0 with macro -> out_par_err=1 with out_byte_valid; without macro -> 0.
REQ-038 SOF, 7 bits of 0x26, EOF -> out_short_frame=1, out_byte=0x26, no out_byte_valid.
REQ-039 SOF, 0x93 + parity, 3 bits, EOF -> one byte delivered, out_frame_err=1.
REQ-040 MAX_BYTES=2, three bytes sent -> two out_byte_valid, out_ovf=1, out_byte_cnt=2.
REQ-041 in_rst pulse after 4 data bits, then a new frame with 0x52 -> no stale strobe, 0x52 delivered correctly.
